// File: rtl/masked_sbox_sched_if.sv
// Handshake bundle between the masked S-box scheduler and its surroundings:
// input shares, PRNG words, per-stage enables, output and drain control.
interface masked_sbox_sched_if #(
  parameter int STAGES = 3,
  parameter int RND_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              rnd_valid;
  logic [RND_W-1:0]  rnd_data;
  logic              rnd_ready;
  logic [STAGES-1:0] stage_en;
  logic [RND_W-1:0]  rnd_mul;
  logic              out_valid;
  logic              out_ready;
  logic              flush;
  logic              flush_done;
  logic              busy;

  modport master (
    output in_valid, rnd_valid, rnd_data, out_ready, flush,
    input  in_ready, rnd_ready, stage_en, rnd_mul, out_valid, flush_done, busy
  );

  modport slave (
    input  in_valid, rnd_valid, rnd_data, out_ready, flush,
    output in_ready, rnd_ready, stage_en, rnd_mul, out_valid, flush_done, busy
  );
endinterface

// File: rtl/masked_sbox_sched.sv
// Sequencer for the 2-share masked S-box pipeline: accept/PRNG pairing, randomness
// alignment to the multiplier stage, bubble-gated enables and drain. MASKED_SBOX_SCHED_STATS_EN adds starve_cnt.
module masked_sbox_sched #(
  parameter int STAGES    = 3,
  parameter int MUL_STAGE = 1,
  parameter int RND_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  masked_sbox_sched_if.slave  sbox
`ifdef MASKED_SBOX_SCHED_STATS_EN
  ,
  output logic [15:0]         starve_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] vld_nxt;
  logic [STAGES-1:0] en;
  logic [RND_W-1:0]  rnd_p [0:MUL_STAGE];
  logic              adv;
  logic              open;
  logic              acc;
  logic              done;
  logic              live;

  // Whole-pipe advance: only a held result at the tail can stall it.
  always_comb begin
    adv  = !(vld_p[STAGES-1] && !sbox.out_ready);
    open = adv && sbox.rnd_valid && (state != DRAIN) && !sbox.flush;
    acc  = open && sbox.in_valid;
  end

  always_comb begin
    en    = '0;
    en[0] = acc;
    for (int i = 1; i < STAGES; i++) begin
      en[i] = adv && vld_p[i-1];
    end
  end

  always_comb begin
    vld_nxt = vld_p;
    if (adv) begin
      vld_nxt = {vld_p[STAGES-2:0], acc};
    end
  end

  // stage p0..pN-1: token-valid shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p <= vld_nxt;
    end
  end

  // stage p0..p(MUL_STAGE): randomness follows its token up to the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= MUL_STAGE; i++) begin
        rnd_p[i] <= '0;
      end
    end else begin
      if (acc) begin
        rnd_p[0] <= sbox.rnd_data;
      end
      for (int i = 1; i <= MUL_STAGE; i++) begin
        if (en[i]) begin
          rnd_p[i] <= rnd_p[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (sbox.flush) begin
          state_nxt = DRAIN;
        end else if (acc) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (sbox.flush) begin
          state_nxt = DRAIN;
        end else if (vld_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (vld_p == '0) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is held, independent of the clock.
  assign live            = ~rst;
  assign sbox.in_ready   = open & live;
  assign sbox.rnd_ready  = acc & live;
  assign sbox.stage_en   = en & {STAGES{live}};
  assign sbox.rnd_mul    = rnd_p[MUL_STAGE];
  assign sbox.out_valid  = vld_p[STAGES-1];
  assign sbox.flush_done = done & live;
  assign sbox.busy       = |vld_p;

`ifdef MASKED_SBOX_SCHED_STATS_EN
  logic starve;

  assign starve = sbox.in_valid && adv && !sbox.rnd_valid && (state != DRAIN) && !sbox.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (starve && (starve_cnt != 16'hFFFF)) begin
      starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/masked_sbox_sched.md
Name: masked_sbox_sched

Overview:
- Sequencer for the 2-share masked S-box pipeline built around the compressed GF(2^4) multiplier stage.
- Accepts share pairs through a valid/ready handshake and draws exactly one fresh randomness word (r0 and r1) per S-box operation from the PRNG.
- Aligns each randomness word with its token at the multiplier stage.
- Drives per-stage register enables so empty (bubble) stages never toggle, handles output backpressure, and supports a controlled drain.

Parameters:
- STAGES, 3, number of register stages in the S-box pipeline (legal range 2..8).
- MUL_STAGE, 1, stage index whose registers feed the GF(2^4) multiplier stage (0 ≤ MUL_STAGE < STAGES).
- RND_W, 8, fresh random bits per operation: r0 = rnd[3:0], r1 = rnd[7:4].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  share pair presented at S-box input.
- in_ready  out  1  scheduler accepts the input this cycle.
- rnd_valid  in  1  PRNG word available.
- rnd_data  in  RND_W  PRNG word.
- rnd_ready  out  1  PRNG word consumed this cycle.
- stage_en  out  STAGES  per-stage register enable for the datapath.
- rnd_mul  out  RND_W  randomness aligned to the token in stage MUL_STAGE.
- out_valid  out  1  result shares valid at pipeline output.
- out_ready  in  1  downstream accepts the result.
- flush  in  1  level; stop accepting and drain the pipeline.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  at least one token in flight.

Behaviour:
- State held in: valid vector v[STAGES-1:0], randomness pipe rp[0..MUL_STAGE] of RND_W bits each, and FSM {IDLE, RUN, DRAIN}.
- Reset values:
  - v = 0, all rp = 0, FSM = IDLE.
  - Outputs: in_ready = 0, rnd_ready = 0, stage_en = 0, rnd_mul = 0, out_valid = 0, flush_done = 0, busy = 0.
  - Reset asserted mid-operation discards all in-flight tokens immediately; no flush_done is generated.
- Advance:
  - adv = !(v[STAGES-1] & !out_ready).
  - The pipeline advances as a whole. A stall freezes every stage, including bubbles.
- Accept:
  - acc = adv & in_valid & rnd_valid & (FSM != DRAIN) & !flush.
  - in_ready = adv & rnd_valid & (FSM != DRAIN) & !flush. This output is combinational and does not depend on in_valid.
  - rnd_ready = acc. Exactly one PRNG word is consumed per accepted token. A word is never reused and never consumed without a token.
- Enables:
  - stage_en[0] = acc.
  - stage_en[i] = adv & v[i-1] for i ≥ 1.
  - A stage holding a bubble, or frozen by a stall, has its enable low.
- Valid shift on adv: v[0] ← acc, v[i] ← v[i-1]. With no adv, v holds.
- Randomness:
  - rp[0] loads rnd_data when acc.
  - rp[i] loads rp[i-1] when stage_en[i].
  - rnd_mul = rp[MUL_STAGE], held stable while that stage is stalled or empty.
- Output: out_valid = v[STAGES-1]. A result is delivered on out_valid & out_ready.
- Latency: with no stalls, a token accepted at cycle t gives out_valid at t+STAGES. Throughput is 1 token/cycle.
- PRNG starvation (rnd_valid = 0): no accept; tokens already in flight keep advancing.
- FSM transitions:
  - IDLE → RUN on acc.
  - RUN → IDLE when v becomes 0 and there is no acc.
  - RUN or IDLE → DRAIN when flush = 1.
  - DRAIN → IDLE when v == 0. flush_done pulses in the cycle the FSM leaves DRAIN.
  - flush asserted while v == 0: DRAIN lasts one cycle, then flush_done.
  - flush must be held until flush_done; deasserting it early still completes the drain.
- busy = |v.

Optional Feature:
- Macro: MASKED_SBOX_SCHED_STATS_EN.
- When defined, adds output port starve_cnt (16 bits).
  - Increments in each cycle where in_valid & adv & !rnd_valid & (FSM != DRAIN) & !flush holds.
  - Saturates at 0xFFFF.
  - Cleared by rst only.
- When undefined: no port, no counter logic, and behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid = rnd_valid = out_ready = 1 constant for 5 cycles, with STAGES = 3 → in_ready = 1 every cycle; out_valid first at cycle 3 after first accept; 5 results; rnd_ready high exactly 5 cycles.
- Feed rnd_data = 0x11, 0x22, 0x33 on consecutive accepts → rnd_mul shows 0x11, 0x22, 0x33 in the cycles where stage_en[MUL_STAGE] has just fired for each token, with MUL_STAGE = 1.
- Fill the pipe, then out_ready = 0 for 4 cycles → stage_en = 0, in_ready = 0, out_valid held, rnd_mul unchanged; on out_ready = 1, outputs resume in order with no loss or duplication.
- in_valid = 1, rnd_valid toggling 1,0,0,1 → accepts only in cycles 0 and 3; bubble stages show stage_en low; with the macro defined, starve_cnt = 2.
- Two tokens in flight, assert flush → in_ready = 0 immediately; both tokens delivered; flush_done pulses once, 1 cycle after the last token leaves; FSM returns to IDLE.
- Assert rst mid-stream with 3 tokens in flight → all outputs 0 asynchronously; after release, no stale out_valid appears.
